// File: rtl/tt_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tt_pkg
// Description : Shared FSM state type and table-depth helper for the sweeper.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic int TT_DEPTH(input int n);
        return 1 << n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tt_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : tt_settle_timer
// Description : Loadable down-counter that stops at zero; flags zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_settle_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Walks every input vector of a combinational block, samples F,
//               and builds the full truth table plus its minterm count.
//               Optional golden-table compare when TT_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int N_IN          = 5,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic [N_IN-1:0]           vec_out,
    input  logic                      f_in,
    output logic                      busy,
    output logic                      done,
    output logic [TT_DEPTH(N_IN)-1:0] table_out,
`ifdef TT_CHECK_EN
    input  logic [TT_DEPTH(N_IN)-1:0] expected,
    output logic                      mismatch,
    output logic [N_IN-1:0]           first_fail,
`endif
    output logic [N_IN:0]             ones_count
);

    localparam int                  c_depth = TT_DEPTH(N_IN);
    localparam int                  c_tw    = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [c_tw-1:0]     c_load  = c_tw'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]     c_last  = N_IN'(c_depth - 1);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("truth_table_sweeper: SETTLE_CYCLES must be at least 1");
    end
    if ((N_IN < 1) || (N_IN > 8)) begin : g_bad_width
        $error("truth_table_sweeper: N_IN must be in 1..8");
    end

    state_t              r_state, w_next;
    logic [N_IN-1:0]     r_vec;
    logic [c_depth-1:0]  r_table;
    logic [N_IN:0]       r_ones;
    logic                w_load, w_dec, w_timer_zero, w_last;

    assign w_last = (r_vec == c_last);

    tt_settle_timer #(
        .WIDTH (c_tw)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_dec   (w_dec),
        .i_value (c_load),
        .o_zero  (w_timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_dec  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_SETTLE;
                    w_load = 1'b1;
                end
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (w_timer_zero) w_next = ST_SAMPLE;
                else              w_dec  = 1'b1;
            end
            ST_SAMPLE: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_SETTLE;
                    w_load = 1'b1;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // The vector never wraps inside a sweep; it parks on the last entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec   <= '0;
            r_table <= '0;
            r_ones  <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_vec   <= '0;
            r_table <= '0;
            r_ones  <= '0;
        end else if (r_state == ST_SAMPLE) begin
            r_table[r_vec] <= f_in;
            r_ones         <= r_ones + {{N_IN{1'b0}}, f_in};
            if (!w_last) r_vec <= r_vec + 1'b1;
        end
    end

    assign vec_out    = r_vec;
    assign table_out  = r_table;
    assign ones_count = r_ones;

`ifdef TT_CHECK_EN
    logic [c_depth-1:0] r_expected;
    logic               r_any_fail;
    logic               r_mismatch;
    logic [N_IN-1:0]    r_first_fail;
    logic               w_entry_bad;

    assign w_entry_bad = (f_in != r_expected[r_vec]);

    // Entries are visited in ascending order, so the first miss is the lowest index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_expected   <= '0;
            r_any_fail   <= 1'b0;
            r_mismatch   <= 1'b0;
            r_first_fail <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_expected   <= expected;
            r_any_fail   <= 1'b0;
            r_mismatch   <= 1'b0;
            r_first_fail <= '0;
        end else if (r_state == ST_SAMPLE) begin
            if (w_entry_bad && !r_any_fail) begin
                r_any_fail   <= 1'b1;
                r_first_fail <= r_vec;
            end
            if (w_last) r_mismatch <= r_any_fail | w_entry_bad;
        end
    end

    assign mismatch   = r_mismatch;
    assign first_fail = r_first_fail;
`endif

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_sweeper
// Description : Self-checking bench for truth_table_sweeper (N_IN=4, S=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

    localparam int N     = 4;
    localparam int S     = 2;
    localparam int D     = 1 << N;
    localparam int PER   = S + 1;
    localparam int SWEEP = D * PER;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] vec_out;
    logic         f_in;
    logic         busy, done;
    logic [D-1:0] table_out;
    logic [N:0]   ones_count;
    logic [D-1:0] stim = '0;
    logic         noise = 1'b0;
    logic [D-1:0] golden;
`ifdef TT_CHECK_EN
    logic [D-1:0] expected;
    logic         mismatch;
    logic [N-1:0] first_fail;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Expression block under test: a look-up of the stimulus table, optionally glitched.
    assign f_in = stim[vec_out] ^ noise;

    truth_table_sweeper #(
        .N_IN          (N),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .vec_out    (vec_out),
        .f_in       (f_in),
        .busy       (busy),
        .done       (done),
        .table_out  (table_out),
`ifdef TT_CHECK_EN
        .expected   (expected),
        .mismatch   (mismatch),
        .first_fail (first_fail),
`endif
        .ones_count (ones_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic f_expr(input int v, input bit inv_d);
        logic a, b, c, d;
        a = v[3]; b = v[2]; c = v[1]; d = v[0] ^ inv_d;
        return (a ^ b) & (~c | d);
    endfunction

    function automatic logic [D-1:0] build_table(input bit inv_d);
        logic [D-1:0] t;
        for (int v = 0; v < D; v++) t[v] = f_expr(v, inv_d);
        return t;
    endfunction

    function automatic int popcount(input logic [D-1:0] t);
        int n = 0;
        for (int v = 0; v < D; v++) n += int'(t[v]);
        return n;
    endfunction

    function automatic int first_diff(input logic [D-1:0] t, input logic [D-1:0] g);
        for (int v = 0; v < D; v++) if (t[v] != g[v]) return v;
        return 0;
    endfunction

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < SWEEP + 8) begin
            @(posedge clk); #1; k++;
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    task automatic check_results(input string tag, input logic [D-1:0] t);
        check({tag, "_table"}, table_out, t);
        check({tag, "_ones"}, ones_count, popcount(t));
`ifdef TT_CHECK_EN
        check({tag, "_mismatch"}, {31'd0, mismatch}, {31'd0, (t != golden)});
        check({tag, "_first_fail"}, first_fail, first_diff(t, golden));
`endif
    endtask

    task automatic run_sweep(input string tag, input logic [D-1:0] t,
                             input bit glitch, input bit repulse, input bit hold);
        int  k = 0;
        int  done_at = -1;
        bit  order_ok = 1'b1;
        int  extra_done = 0;
        stim = t;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        while (k <= SWEEP + 5) begin
            if (done) begin done_at = k; break; end
            if (!busy || vec_out != N'(k / PER)) order_ok = 1'b0;
            noise = (glitch && (k % PER != S)) ? 1'($urandom) : 1'b0;
            if (repulse) start = (k == 10 || k == 40);
            @(posedge clk); #1; k++;
        end
        noise = 1'b0;
        if (repulse) start = 1'b0;
        check({tag, "_done_cycle"}, done_at, SWEEP);
        check({tag, "_vec_order"}, {31'd0, order_ok}, 32'd1);
        check({tag, "_vec_final"}, vec_out, D - 1);
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
        check_results(tag, t);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        if (hold) begin
            check({tag, "_idle_gap"}, {31'd0, busy}, 32'd0);
            @(posedge clk); #1;
            check({tag, "_restart_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_restart_clear"}, {table_out, 11'd0, ones_count}, 32'd0);
            start = 1'b0;
            wait_done({tag, "_second"});
            check_results({tag, "_second"}, t);
        end else begin
            repeat (6) begin
                @(posedge clk); #1;
                if (done || busy) extra_done++;
            end
            check({tag, "_no_extra_sweep"}, extra_done, 0);
            check_results({tag, "_held"}, t);
        end
    endtask

    task automatic run_reset_abort(input string tag, input logic [D-1:0] t);
        stim = t;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check({tag, "_vec"}, vec_out, 0);
        check({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
        check({tag, "_table"}, table_out, 0);
        check({tag, "_ones"}, ones_count, 0);
`ifdef TT_CHECK_EN
        check({tag, "_mm_ff"}, {27'd0, mismatch, first_fail}, 32'd0);
`endif
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        logic [D-1:0] t_expr;
        logic [D-1:0] t;
        t_expr = build_table(1'b0);
        golden = t_expr;
`ifdef TT_CHECK_EN
        expected = golden;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_vec", vec_out, 0);
        check("reset_busy_done", {30'd0, busy, done}, 32'd0);
        check("reset_table", table_out, 0);
        check("reset_ones", ones_count, 0);
        @(negedge clk); rst_n = 1'b1;

        run_sweep("expr", t_expr, 1'b0, 1'b0, 1'b0);
        check("expr_table_literal", table_out, 32'h0BB0);
        check("expr_ones_literal", ones_count, 6);
        run_sweep("expr_repulse", t_expr, 1'b0, 1'b1, 1'b0);
        run_sweep("expr_glitch", t_expr, 1'b1, 1'b0, 1'b0);
        run_sweep("tied0", '0, 1'b0, 1'b0, 1'b0);
        run_sweep("tied1", '1, 1'b1, 1'b0, 1'b0);
        run_sweep("inv_d", build_table(1'b1), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            t = D'($urandom);
            run_sweep("random", t, 1'b1, 1'b0, 1'b0);
        end
        run_reset_abort("reset_mid", D'($urandom) | D'(32'h0000_00FF));
        run_sweep("after_reset", t_expr, 1'b0, 1'b0, 1'b0);
        run_sweep("hold_start", D'($urandom), 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
